// File: rtl/i2c_channel_arbiter.sv
// Round-robin arbiter that shares one upstream I2C master among NCH extender channels,
// switching the extender select only while the bus is idle between STOP and START.
module i2c_channel_arbiter #(
    parameter int NCH            = 8,
    parameter int SEL_W          = 3,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   grant,
    output logic [SEL_W-1:0] sel,
    output logic             bus_busy,
    output logic             start_det,
    output logic             stop_det,
    output logic             timeout
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [15:0]         TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [SEL_W:0]      NCH_V       = (SEL_W + 1)'(NCH);
    localparam logic [SEL_W-1:0]    OWNER_INIT  = SEL_W'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // First requester strictly after 'last', wrapping at NCH-1.
    function automatic logic [SEL_W-1:0] pick_winner(input logic [NCH-1:0] r,
                                                     input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] win;
        logic             found;
        logic [SEL_W:0]   cand;
        win   = {SEL_W{1'b0}};
        found = 1'b0;
        cand  = {(SEL_W + 1){1'b0}};
        for (int i = 1; i <= NCH; i++) begin
            cand = {1'b0, last} + (SEL_W + 1)'(i);
            cand = (cand >= NCH_V) ? (cand - NCH_V) : cand;
            if (!found && r[cand[SEL_W-1:0]]) begin
                win   = cand[SEL_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NCH-1:0] v;
        v      = {NCH{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    logic             scl_meta_r, scl_sync_r, scl_prev_r;
    logic             sda_meta_r, sda_sync_r, sda_prev_r;
    logic             start_det_r, stop_det_r, bus_busy_r;
    logic             start_s, stop_s, bus_busy_nx_s, force_idle_s;

    state_t           state_r, state_nx;
    logic [SEL_W-1:0] sel_r, sel_nx;
    logic [SEL_W-1:0] owner_r, owner_nx;
    logic [SEL_W-1:0] last_owner_r, last_owner_nx;
    logic [NCH-1:0]   grant_r, grant_nx;
    logic [SETTLE_W-1:0] settle_cnt_r, settle_cnt_nx;
    logic [15:0]      tmo_cnt_r, tmo_cnt_nx;
    logic             timeout_r, timeout_nx;
    logic [SEL_W-1:0] winner_s;

    assign start_s = scl_sync_r & scl_prev_r &  sda_prev_r & ~sda_sync_r;
    assign stop_s  = scl_sync_r & scl_prev_r & ~sda_prev_r &  sda_sync_r;

    // Bus-busy flag: a timeout forcibly frees the bus even without a STOP.
    always_comb begin
        bus_busy_nx_s = bus_busy_r;
        if (force_idle_s) begin
            bus_busy_nx_s = 1'b0;
        end else if (start_s) begin
            bus_busy_nx_s = 1'b1;
        end else if (stop_s) begin
            bus_busy_nx_s = 1'b0;
        end else begin
            bus_busy_nx_s = bus_busy_r;
        end
    end

    // Line synchronizers, START/STOP detect pulses and bus-busy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_meta_r  <= 1'b1;
            scl_sync_r  <= 1'b1;
            scl_prev_r  <= 1'b1;
            sda_meta_r  <= 1'b1;
            sda_sync_r  <= 1'b1;
            sda_prev_r  <= 1'b1;
            start_det_r <= 1'b0;
            stop_det_r  <= 1'b0;
            bus_busy_r  <= 1'b0;
        end else begin
            scl_meta_r  <= scl_in;
            scl_sync_r  <= scl_meta_r;
            scl_prev_r  <= scl_sync_r;
            sda_meta_r  <= sda_in;
            sda_sync_r  <= sda_meta_r;
            sda_prev_r  <= sda_sync_r;
            start_det_r <= start_s;
            stop_det_r  <= stop_s;
            bus_busy_r  <= bus_busy_nx_s;
        end
    end

    // Round-robin candidate for the next IDLE arbitration.
    always_comb begin
        winner_s = pick_winner(req, last_owner_r);
    end

    // Arbitration FSM next-state and registered-output values.
    always_comb begin
        state_nx      = state_r;
        sel_nx        = sel_r;
        owner_nx      = owner_r;
        last_owner_nx = last_owner_r;
        grant_nx      = grant_r;
        settle_cnt_nx = settle_cnt_r;
        tmo_cnt_nx    = tmo_cnt_r;
        timeout_nx    = 1'b0;
        force_idle_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                grant_nx = {NCH{1'b0}};
                if ((|req) && !bus_busy_r) begin
                    sel_nx        = winner_s;
                    owner_nx      = winner_s;
                    settle_cnt_nx = {SETTLE_W{1'b0}};
                    state_nx      = ST_SETTLE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!req[owner_r]) begin
                    state_nx = ST_IDLE;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    grant_nx = onehot(owner_r);
                    state_nx = ST_ACTIVE;
                end else begin
                    settle_cnt_nx = settle_cnt_r + SETTLE_ONE;
                end
            end
            ST_ACTIVE: begin
                if (!req[owner_r] && !bus_busy_r) begin
                    grant_nx      = {NCH{1'b0}};
                    last_owner_nx = owner_r;
                    state_nx      = ST_IDLE;
                end else if (!req[owner_r]) begin
                    tmo_cnt_nx = 16'd0;
                    state_nx   = ST_DRAIN;
                end else begin
                    state_nx = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                if (!bus_busy_r) begin
                    grant_nx      = {NCH{1'b0}};
                    last_owner_nx = owner_r;
                    state_nx      = ST_IDLE;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    // A STOP landing on the terminal count wins over the timeout.
                    grant_nx      = {NCH{1'b0}};
                    last_owner_nx = owner_r;
                    state_nx      = ST_IDLE;
                    timeout_nx    = ~stop_s;
                    force_idle_s  = ~stop_s;
                end else begin
                    tmo_cnt_nx = tmo_cnt_r + 16'd1;
                end
            end
            default: begin
                grant_nx = {NCH{1'b0}};
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Arbitration FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sel_r        <= {SEL_W{1'b0}};
            owner_r      <= {SEL_W{1'b0}};
            last_owner_r <= OWNER_INIT;
            grant_r      <= {NCH{1'b0}};
            settle_cnt_r <= {SETTLE_W{1'b0}};
            tmo_cnt_r    <= 16'd0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_nx;
            sel_r        <= sel_nx;
            owner_r      <= owner_nx;
            last_owner_r <= last_owner_nx;
            grant_r      <= grant_nx;
            settle_cnt_r <= settle_cnt_nx;
            tmo_cnt_r    <= tmo_cnt_nx;
            timeout_r    <= timeout_nx;
        end
    end

    assign grant     = grant_r;
    assign sel       = sel_r;
    assign bus_busy  = bus_busy_r;
    assign start_det = start_det_r;
    assign stop_det  = stop_det_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_i2c_channel_arbiter.sv
// Directed bench for i2c_channel_arbiter: a timestamp-based behavioural model is checked every
// cycle, and directed scenarios pin literal expectations at the key moments.
module tb_i2c_channel_arbiter;

    localparam int NCH    = 8;
    localparam int SEL_W  = 3;
    localparam int SETTLE = 4;
    localparam int TMO    = 16;

    logic             clk = 1'b0;
    logic             rst_n, scl_in, sda_in;
    logic [NCH-1:0]   req, grant;
    logic [SEL_W-1:0] sel;
    logic             bus_busy, start_det, stop_det, timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int tmo_pulses = 0;

    always #5 clk = ~clk;

    i2c_channel_arbiter #(
        .NCH(NCH), .SEL_W(SEL_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in), .req(req),
        .grant(grant), .sel(sel), .bus_busy(bus_busy), .start_det(start_det),
        .stop_det(stop_det), .timeout(timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owner lifecycle is tracked by timestamps: when it was chosen, when it entered drain.
    int m_cyc = 0, m_owner = -1, m_last = NCH - 1, m_sel = 0;
    int m_arb_at = 0, m_drain_at = 0;
    bit m_granted = 0, m_draining = 0, m_busy = 0;
    bit m_start = 0, m_stop = 0, m_timeout = 0, mb_st, mb_sp;
    bit [2:0] hs_scl = 3'b111, hs_sda = 3'b111;  // [k] = raw sample k+1 edges ago

    function automatic logic [NCH-1:0] model_grant();
        logic [NCH-1:0] g;
        g = '0;
        if (m_owner >= 0 && m_granted) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_release();
        m_last     = m_owner;
        m_owner    = -1;
        m_granted  = 0;
        m_draining = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_last = NCH - 1; m_sel = 0; m_granted = 0; m_draining = 0;
            m_busy = 0; m_start = 0; m_stop = 0; m_timeout = 0;
            hs_scl = 3'b111; hs_sda = 3'b111;
        end else begin
            m_cyc++;
            mb_st  = hs_scl[1] && hs_scl[2] &&  hs_sda[2] && !hs_sda[1];
            mb_sp  = hs_scl[1] && hs_scl[2] && !hs_sda[2] &&  hs_sda[1];
            hs_scl = {hs_scl[1:0], scl_in};
            hs_sda = {hs_sda[1:0], sda_in};
            m_timeout = 0;
            if (m_owner < 0) begin
                if (req != 0 && !m_busy) begin
                    for (int i = 1; i <= NCH; i++) begin
                        if (req[(m_last + i) % NCH]) begin
                            m_owner = (m_last + i) % NCH;
                            break;
                        end
                    end
                    m_sel = m_owner;
                    m_arb_at = m_cyc;
                end
            end else if (!m_granted) begin
                if (!req[m_owner]) m_owner = -1;
                else if (m_cyc == m_arb_at + SETTLE) m_granted = 1;
            end else if (!m_draining) begin
                if (!req[m_owner]) begin
                    if (!m_busy) model_release();
                    else begin m_draining = 1; m_drain_at = m_cyc; end
                end
            end else begin
                if (!m_busy) model_release();
                else if (m_cyc == m_drain_at + TMO) begin
                    m_timeout = !mb_sp;
                    model_release();
                end
            end
            if (mb_st) m_busy = 1;
            else if (mb_sp) m_busy = 0;
            if (m_timeout) m_busy = 0;
            m_start = mb_st;
            m_stop  = mb_sp;
        end
    end

    // Every-cycle comparison against the model, just after the active edge.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("grant", grant, model_grant());
            check("sel", sel, m_sel);
            check("bus_busy", bus_busy, m_busy);
            check("start_det", start_det, m_start);
            check("stop_det", stop_det, m_stop);
            check("timeout", timeout, m_timeout);
            if (timeout) tmo_pulses++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(input logic [NCH-1:0] exp_g, input logic [SEL_W-1:0] exp_s,
                              input string name);
        int k;
        k = 0;
        while (grant == '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, grant, exp_g);
        check({name, "_sel"}, sel, exp_s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b1; req = '0; scl_in = 1'b1; sda_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 8'h00);
        check("rst_sel", sel, 3'd0);
        check("rst_busy", bus_busy, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Basic grant latency and release
        req = 8'h04;
        tick(1);
        check("basic_sel", sel, 3'd2);
        check("basic_model_sel", m_sel, 2);
        check("basic_grant_early", grant, 8'h00);
        tick(3);
        check("basic_grant_k3", grant, 8'h00);
        tick(1);
        check("basic_grant", grant, 8'h04);
        check("basic_model_grant", model_grant(), 8'h04);
        req = 8'h00;
        tick(1);
        check("basic_release", grant, 8'h00);

        // Round robin between channels 0 and 7
        do_reset();
        req = 8'h81;
        wait_grant(8'h01, 3'd0, "rr0");
        req = 8'h80; tick(1); req = 8'h81;
        wait_grant(8'h80, 3'd7, "rr1");
        req = 8'h01; tick(1); req = 8'h81;
        wait_grant(8'h01, 3'd0, "rr2");
        req = 8'h80; tick(1); req = 8'h81;
        wait_grant(8'h80, 3'd7, "rr3");
        req = 8'h00;
        tick(2);

        // Bus-busy gating
        sda_in = 1'b0;
        tick(2);
        check("gate_start_early", start_det, 1'b0);
        tick(1);
        check("gate_start_det", start_det, 1'b1);
        check("gate_busy", bus_busy, 1'b1);
        tick(1);
        check("gate_start_pulse", start_det, 1'b0);
        req = 8'h02;
        tick(8);
        check("gate_sel_held", sel, 3'd7);
        check("gate_no_grant", grant, 8'h00);
        sda_in = 1'b1;
        tick(3);
        check("gate_stop_det", stop_det, 1'b1);
        check("gate_idle", bus_busy, 1'b0);
        check("gate_sel_still", sel, 3'd7);
        tick(1);
        check("gate_sel_new", sel, 3'd1);
        tick(3);
        check("gate_grant_early", grant, 8'h00);
        tick(1);
        check("gate_grant", grant, 8'h02);
        req = 8'h00;
        tick(2);

        // Drain: owner 3 releases mid-transaction, STOP arrives before timeout
        req = 8'h08;
        wait_grant(8'h08, 3'd3, "drain_grant");
        sda_in = 1'b0; tick(4);
        check("drain_busy", bus_busy, 1'b1);
        scl_in = 1'b0; tick(3); sda_in = 1'b1; tick(3); scl_in = 1'b1; tick(3);
        scl_in = 1'b0; tick(3); sda_in = 1'b0; tick(3); scl_in = 1'b1; tick(3);
        check("drain_data_busy", bus_busy, 1'b1);
        req = 8'h00;
        tick(2);
        check("drain_hold", grant, 8'h08);
        sda_in = 1'b1;
        tick(3);
        check("drain_stop", stop_det, 1'b1);
        check("drain_idle", bus_busy, 1'b0);
        check("drain_grant_held", grant, 8'h08);
        tick(1);
        check("drain_release", grant, 8'h00);
        check("drain_no_timeout", tmo_pulses, 0);

        // Timeout: owner 5 leaves the bus busy with no STOP
        req = 8'h20;
        wait_grant(8'h20, 3'd5, "tmo_grant");
        sda_in = 1'b0; tick(4);
        check("tmo_busy", bus_busy, 1'b1);
        req = 8'h10;
        for (int i = 0; i < TMO; i++) begin
            tick(1);
            check("tmo_quiet", timeout, 1'b0);
            check("tmo_hold", grant, 8'h20);
        end
        tick(1);
        check("tmo_pulse", timeout, 1'b1);
        check("tmo_busy_clr", bus_busy, 1'b0);
        check("tmo_grant_clr", grant, 8'h00);
        tick(1);
        check("tmo_next_sel", sel, 3'd4);
        check("tmo_one_shot", timeout, 1'b0);
        wait_grant(8'h10, 3'd4, "tmo_next");
        check("tmo_count", tmo_pulses, 1);
        sda_in = 1'b1; tick(4);
        req = 8'h00;
        tick(2);

        // Asynchronous reset mid-grant
        req = 8'h20;
        wait_grant(8'h20, 3'd5, "arst_grant");
        sda_in = 1'b0; tick(4);
        check("arst_busy", bus_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_grant_clr", grant, 8'h00);
        check("arst_sel_clr", sel, 3'd0);
        check("arst_busy_clr", bus_busy, 1'b0);
        sda_in = 1'b1;
        req = 8'h21;
        tick(2);
        rst_n = 1'b1;
        wait_grant(8'h01, 3'd0, "arst_first");
        req = 8'h00;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
